fir_out_stage: RTL and testbench

//  Downstream consumer of the FIR core's 11-bit signed output sample stream.

---
 rtl/fir_out_stage_pkg.sv | 37 +++
 rtl/fir_out_fifo.sv | 56 +++++
 rtl/fir_out_stage.sv | 83 ++++++++
 tb/tb_fir_out_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fir_out_stage_pkg.sv
// Shared widths, saturation bounds and the round/shift/saturate helper
// for the FIR output stage.
package fir_out_stage_pkg;

    localparam int unsigned InW    = 11;
    localparam int unsigned OutW   = 8;
    localparam int unsigned ShiftW = 2;
    localparam int unsigned Depth  = 4;
    localparam int unsigned LevelW = $clog2(Depth) + 1;
    localparam int unsigned SumW   = InW + 1;
    localparam int unsigned DropW  = 8;

    localparam int SatMax = 2 ** (OutW - 1) - 1;
    localparam int SatMin = -(2 ** (OutW - 1));

    // Round half toward +inf, arithmetic shift, then clamp to the OutW signed range.
    // One guard bit in SumW keeps the rounding add from wrapping.
    function automatic logic [OutW-1:0] scale_sat(input logic [InW-1:0] x,
                                                  input logic [ShiftW-1:0] s);
        logic signed [SumW-1:0] t;
        logic signed [SumW-1:0] r;
        int rv;
        t = signed'({x[InW-1], x});
        if (s != '0) begin
            t = t + (SumW'(1) << (s - 1'b1));
        end
        r  = t >>> s;
        rv = int'(r);
        if (rv > SatMax) begin
            return OutW'(SatMax);
        end else if (rv < SatMin) begin
            return OutW'(SatMin);
        end
        return r[OutW-1:0];
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous first-word-fall-through FIFO; head is presented combinationally,
// forced to zero while empty.
module fir_out_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        // Extra pointer MSB differs only when the write side has lapped the read side.
        full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                  (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        // A pop frees the slot in the same cycle, so push on full succeeds alongside it.
        push_ok = push_i && (!full_o || pop_i);
        pop_ok  = pop_i && !empty_o;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_o  = wr_ptr_q - rd_ptr_q;
        rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && push_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: registered round/shift/saturate to 8 bits, FWFT buffering,
// and sticky overflow plus saturating drop counter.
module fir_out_stage
    import fir_out_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [InW-1:0]    in_data,
    input  logic [ShiftW-1:0] shift,
    input  logic              pop,
    input  logic              clr_stat,
    output logic [OutW-1:0]   out_data,
    output logic              out_valid,
    output logic [LevelW-1:0] fifo_level,
    output logic              overflow,
    output logic [DropW-1:0]  drop_cnt
);

    logic            v1_q;
    logic [OutW-1:0] d1_q;
    logic            overflow_q, overflow_d;
    logic [DropW-1:0] drop_cnt_q, drop_cnt_d;
    logic            fifo_empty;
    logic            fifo_full;
    logic            drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= in_valid;
            d1_q <= scale_sat(in_data, shift);
        end
    end

    fir_out_fifo #(
        .Width (OutW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (v1_q),
        .pop_i   (pop),
        .wdata_i (d1_q),
        .rdata_o (out_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        drop       = v1_q && fifo_full && !pop;
        // Clearing wins over a drop in the same cycle.
        if (clr_stat) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage: scaling, latency, FIFO corner cases,
// drop statistics and mid-stream reset.
module tb_fir_out_stage;
    import fir_out_stage_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [InW-1:0]    in_data;
    logic [ShiftW-1:0] shift;
    logic              pop;
    logic              clr_stat;
    logic [OutW-1:0]   out_data;
    logic              out_valid;
    logic [LevelW-1:0] fifo_level;
    logic              overflow;
    logic [DropW-1:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_out_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .shift      (shift),
        .pop        (pop),
        .clr_stat   (clr_stat),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int value, input int s);
        in_valid = 1'b1;
        in_data  = InW'(value);
        shift    = ShiftW'(s);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; shift = '0; pop = 1'b0; clr_stat = 1'b0;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", $signed(out_data), 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b0;

        // 1: saturation at shift 0, two-cycle latency
        send(300, 0); tick();
        chk("t1_lat_valid", out_valid, 0);
        send(-300, 0); tick();
        chk("t1_head0", $signed(out_data), 127);
        chk("t1_level", fifo_level, 1);
        pop = 1'b1; send(5, 0); tick();
        chk("t1_head1", $signed(out_data), -128);
        in_valid = 1'b0; tick();
        chk("t1_head2", $signed(out_data), 5);
        tick();
        chk("t1_empty", out_valid, 0);
        chk("t1_empty_data", $signed(out_data), 0);
        pop = 1'b0;

        // 2: rounding with shift
        send(301, 2); tick();
        send(-6, 2); tick();
        chk("t2_301s2", $signed(out_data), 75);
        pop = 1'b1; send(-5, 1); tick();
        chk("t2_m6s2", $signed(out_data), -1);
        send(3, 1); tick();
        chk("t2_m5s1", $signed(out_data), -2);
        in_valid = 1'b0; tick();
        chk("t2_3s1", $signed(out_data), 2);
        tick();
        chk("t2_empty", out_valid, 0);
        pop = 1'b0;

        // 3: overfill with 1..6, then drain
        for (int i = 1; i <= 6; i++) begin
            send(i, 0); tick();
        end
        in_valid = 1'b0; tick();
        chk("t3_level", fifo_level, 4);
        chk("t3_head", $signed(out_data), 1);
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_cnt, 2);
        pop = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain", $signed(out_data), i);
            tick();
        end
        chk("t3_drained", out_valid, 0);
        pop = 1'b0;

        // 4: push+pop on full, pop on empty, push+pop on empty
        for (int i = 1; i <= 4; i++) begin
            send(10 * i, 0); tick();
        end
        in_valid = 1'b0; tick();
        chk("t4_full", fifo_level, 4);
        send(50, 0); tick();
        in_valid = 1'b0; pop = 1'b1; tick();
        chk("t4_fullpp_level", fifo_level, 4);
        chk("t4_fullpp_head", $signed(out_data), 20);
        chk("t4_fullpp_drop", drop_cnt, 2);
        tick(); tick(); tick();
        chk("t4_last", $signed(out_data), 50);
        tick();
        chk("t4_empty_level", fifo_level, 0);
        tick();
        chk("t4_underflow_level", fifo_level, 0);
        chk("t4_underflow_valid", out_valid, 0);
        send(7, 0); tick();
        in_valid = 1'b0; tick();
        chk("t4_emptypp_level", fifo_level, 1);
        chk("t4_emptypp_head", $signed(out_data), 7);
        tick();
        pop = 1'b0;
        chk("t4_clean", fifo_level, 0);

        // 5: drop-counter saturation and clr_stat priority
        for (int i = 0; i < 304; i++) begin
            send(i % 100, 0); tick();
        end
        in_valid = 1'b0; tick();
        chk("t5_sat", drop_cnt, 255);
        chk("t5_ovf", overflow, 1);
        send(1, 0); tick();
        in_valid = 1'b0; clr_stat = 1'b1; tick();
        clr_stat = 1'b0;
        chk("t5_clr_ovf", overflow, 0);
        chk("t5_clr_drop", drop_cnt, 0);
        chk("t5_clr_level", fifo_level, 4);

        // 6: reset with 3 entries and a sample in stage 1
        pop = 1'b1; tick(); pop = 1'b0;
        chk("t6_pre_level", fifo_level, 3);
        send(9, 0); tick();
        in_valid = 1'b0; reset = 1'b1; tick();
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", $signed(out_data), 0);
        reset = 1'b0; tick();
        chk("t6_post_level", fifo_level, 0);
        chk("t6_post_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
